nor_operand_loader: RTL and testbench

//  Sequential front/back end for the combinational N-bit bitwise NOR gate.
//  - Accepts operands A then B over one valid/ready byte stream.
//  - Holds both operands in registers that drive the NOR gate inputs.
//  - Captures the gate result into an output register with a valid/ready handshake.
//  - Sits between a stream source (UART/testbench/FIFO) and the NOR primitive.

---
 rtl/nor_operand_loader.sv | 92 +++++++++
 tb/tb_nor_operand_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_operand_loader.sv
// Stream loader around an external N-bit NOR gate: collects operand A then B,
// captures the gate output and offers it on a valid/ready port. Option: NOR_LOADER_PARITY_EN.
module nor_operand_loader #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    input  logic [DATA_WIDTH-1:0] nor_y,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
`ifdef NOR_LOADER_PARITY_EN
    output logic                  out_parity,
`endif
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_CAP = 2'd2,
        S_OUT = 2'd3
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] op_a_q;
    logic [DATA_WIDTH-1:0] op_b_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
`ifdef NOR_LOADER_PARITY_EN
    logic                  out_parity_q;
`endif

    // Ready is a pure state decode, forced low while reset is held.
    assign in_ready  = rst_n & ((state_q == S_A) | (state_q == S_B));
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
`ifdef NOR_LOADER_PARITY_EN
    assign out_parity = out_parity_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_A;
            op_a_q       <= '0;
            op_b_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
`ifdef NOR_LOADER_PARITY_EN
            out_parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_A: begin
                    if (in_valid) begin
                        op_a_q  <= in_data;
                        state_q <= S_B;
                    end
                end
                S_B: begin
                    if (in_valid) begin
                        op_b_q  <= in_data;
                        state_q <= S_CAP;
                    end
                end
                // Gate output has had a full cycle to settle from the new op_b.
                S_CAP: begin
                    out_data_q   <= nor_y;
                    out_valid_q  <= 1'b1;
`ifdef NOR_LOADER_PARITY_EN
                    out_parity_q <= ^nor_y;
`endif
                    state_q      <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_A;
                    end
                end
                default: state_q <= S_A;
            endcase
        end
    end

endmodule

// File: tb/tb_nor_operand_loader.sv
// Randomized self-checking bench for nor_operand_loader against a pair-level
// scoreboard model; exercises parity too when NOR_LOADER_PARITY_EN is defined.
module tb_nor_operand_loader;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] nor_y;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
`ifdef NOR_LOADER_PARITY_EN
    logic          out_parity;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_exp    = 0;
    int n_out    = 0;
    bit rand_rdy = 1'b0;

    // Reference model state: partial pair plus queue of expected results.
    bit            have_a = 1'b0;
    logic [DW-1:0] last_a, last_b;
    logic [DW-1:0] exp_q[$];
    int            stage = 0;
    bit            chk_a = 1'b0;
    bit            hold = 1'b0;
    bit            post_out = 1'b0;
    logic [DW-1:0] hold_data;

    always #5 clk = ~clk;

    assign nor_y = ~(op_a | op_b);

    nor_operand_loader #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .nor_y     (nor_y),
        .out_data  (out_data),
        .out_valid (out_valid),
`ifdef NOR_LOADER_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready (out_ready)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: handshakes sampled at negedge are the transfers of the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            have_a   = 1'b0;
            exp_q.delete();
            stage    = 0;
            chk_a    = 1'b0;
            hold     = 1'b0;
            post_out = 1'b0;
        end else begin
            if (chk_a) begin
                chk_eq("op_a", op_a, last_a);
                chk_a = 1'b0;
            end
            if (stage == 1) begin
                chk_eq("op_b", op_b, last_b);
                chk_eq("cap_valid", out_valid, 0);
                stage = 2;
            end else if (stage == 2) begin
                chk_eq("lat_valid", out_valid, 1);
                stage = 0;
            end
            if (hold) begin
                chk_eq("hold_valid", out_valid, 1);
                chk_eq("hold_data", out_data, hold_data);
            end
            if (out_valid)
                chk_eq("rdy_block", in_ready, 0);
            if (post_out) begin
                chk_eq("drop_valid", out_valid, 0);
                chk_eq("ready_after", in_ready, 1);
                post_out = 1'b0;
            end
            hold      = out_valid && !out_ready;
            hold_data = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk_eq("spurious", 1, 0);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    chk_eq("result", out_data, e);
`ifdef NOR_LOADER_PARITY_EN
                    chk_eq("parity", out_parity, ^e);
`endif
                end
                n_out++;
                post_out = 1'b1;
            end
            if (in_valid && in_ready) begin
                if (!have_a) begin
                    last_a = in_data;
                    have_a = 1'b1;
                    chk_a  = 1'b1;
                end else begin
                    last_b = in_data;
                    exp_q.push_back(~(last_a | in_data));
                    n_exp++;
                    have_a = 1'b0;
                    stage  = 1;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [DW-1:0] b, input int max_gap);
        int gap;
        bit done;
        gap  = $urandom_range(0, max_gap);
        done = 1'b0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) chk_eq("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) chk_eq("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        chk_eq("rst_out_valid", out_valid, 0);
        chk_eq("rst_out_data", out_data, 0);
        chk_eq("rst_op_a", op_a, 0);
        chk_eq("rst_op_b", op_b, 0);
        chk_eq("rst_in_ready", in_ready, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("release_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Directed: F0 NOR 0F with sink ready
        out_ready = 1'b1;
        send(8'hF0, 0);
        send(8'h0F, 0);
        wait_idle();

        // Directed: 00 NOR 00 held by a stalled sink
        out_ready = 1'b0;
        send(8'h00, 0);
        send(8'h00, 0);
        repeat (6) @(negedge clk);
        chk_eq("stall_valid", out_valid, 1);
        chk_eq("stall_data", out_data, 8'hFF);
        chk_eq("stall_ready", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();

        // Directed: back-to-back pairs with random gaps and sink stalls
        rand_rdy = 1'b1;
        send(8'hA0, 3);
        send(8'h0A, 3);
        send(8'hAA, 3);
        send(8'h55, 3);
        rand_rdy  = 1'b0;
        #0;
        out_ready = 1'b1;
        wait_idle();

        // Reset mid-pair: 12 must be discarded
        send(8'h12, 0);
        send(8'h5A, 0);
        send(8'h33, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h12, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_eq("abort_op_a", op_a, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'hFF, 1);
        send(8'h00, 1);
        wait_idle();

`ifdef NOR_LOADER_PARITY_EN
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'h03, 0);
        send(8'h00, 0);
        wait_idle();
`endif

        // Random pairs against the scoreboard
        rand_rdy = 1'b1;
        for (int p = 0; p < 30; p++) begin
            send(DW'($urandom), 3);
            send(DW'($urandom), 3);
        end
        rand_rdy = 1'b0;
        #2;
        out_ready = 1'b1;
        wait_idle();

        chk_eq("result_count", n_out, n_exp);
        chk_eq("no_partial", have_a, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
